// File: rtl/control_pkg.sv
// Shared definitions for the 8-phase MCU control decoder: opcode and phase
// encodings, the strobe bundle type and the accumulator-operand predicate.
package control_pkg;

  // Opcode encodings held in the instruction register
  localparam logic [2:0] OP_HLT = 3'd0;
  localparam logic [2:0] OP_SKZ = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_AND = 3'd3;
  localparam logic [2:0] OP_XOR = 3'd4;
  localparam logic [2:0] OP_LDA = 3'd5;
  localparam logic [2:0] OP_STO = 3'd6;
  localparam logic [2:0] OP_JMP = 3'd7;

  // Instruction-cycle phases driven by the external phase counter
  localparam logic [2:0] PH_INST_ADDR  = 3'd0;
  localparam logic [2:0] PH_INST_FETCH = 3'd1;
  localparam logic [2:0] PH_INST_LOAD  = 3'd2;
  localparam logic [2:0] PH_IDLE       = 3'd3;
  localparam logic [2:0] PH_OP_ADDR    = 3'd4;
  localparam logic [2:0] PH_OP_FETCH   = 3'd5;
  localparam logic [2:0] PH_ALU_OP     = 3'd6;
  localparam logic [2:0] PH_STORE      = 3'd7;

  // Datapath strobes, MSB first
  typedef struct packed {
    logic ld_acc;
    logic ld_mdr;
    logic ld_ir;
    logic dout_en;
    logic ld_pc;
    logic inc;
    logic sel;
    logic rd;
    logic wr;
  } ctrl_t;

  localparam ctrl_t CTRL_NONE = ctrl_t'(9'd0);

  // Opcodes that fetch a memory operand into the accumulator path
  function automatic logic is_aluop(input logic [2:0] op_code);
    return (op_code == OP_ADD) || (op_code == OP_AND) ||
           (op_code == OP_XOR) || (op_code == OP_LDA);
  endfunction

endpackage

// File: rtl/control_logic_if.sv
// Decoder bus: opcode/phase/zero inputs and the strobe/phase/halt outputs.
interface control_logic_if;
  logic [2:0] op;
  logic [2:0] pstate;
  logic       zero;
  logic       ld_acc;
  logic       ld_mdr;
  logic       ld_ir;
  logic       dout_en;
  logic       ld_pc;
  logic       inc;
  logic       sel;
  logic       rd;
  logic       wr;
  logic [2:0] nstate;
  logic       halted;

  modport master (
    output op, pstate, zero,
    input  ld_acc, ld_mdr, ld_ir, dout_en, ld_pc, inc, sel, rd, wr, nstate, halted
  );

  modport slave (
    input  op, pstate, zero,
    output ld_acc, ld_mdr, ld_ir, dout_en, ld_pc, inc, sel, rd, wr, nstate, halted
  );
endinterface

// File: rtl/control_decode.sv
// Purely combinational phase/opcode decoder producing the datapath strobes.
module control_decode
  import control_pkg::*;
(
  input  logic [2:0] op,
  input  logic [2:0] pstate,
  input  logic       zero,
  output ctrl_t      ctrl
);

  logic aluop_s;

  // Strobe table: everything not named for a phase stays low
  always_comb begin
    aluop_s = is_aluop(op);
    ctrl    = CTRL_NONE;
    case (pstate)
      PH_INST_ADDR: begin
        ctrl.sel = 1'b1;
      end
      PH_INST_FETCH: begin
        ctrl.sel = 1'b1;
        ctrl.rd  = 1'b1;
      end
      PH_INST_LOAD, PH_IDLE: begin
        ctrl.sel   = 1'b1;
        ctrl.rd    = 1'b1;
        ctrl.ld_ir = 1'b1;
      end
      PH_OP_ADDR: begin
        ctrl.inc = 1'b1;
      end
      PH_OP_FETCH: begin
        ctrl.rd     = aluop_s;
        ctrl.ld_mdr = aluop_s;
      end
      PH_ALU_OP: begin
        ctrl.rd      = aluop_s;
        ctrl.ld_mdr  = aluop_s;
        ctrl.inc     = (op == OP_SKZ) && zero;
        ctrl.ld_pc   = (op == OP_JMP);
        ctrl.dout_en = (op == OP_STO);
      end
      PH_STORE: begin
        ctrl.rd      = aluop_s;
        ctrl.ld_acc  = aluop_s;
        ctrl.ld_pc   = (op == OP_JMP);
        ctrl.wr      = (op == OP_STO);
        ctrl.dout_en = (op == OP_STO);
      end
      default: begin
        ctrl = CTRL_NONE;
      end
    endcase
  end

endmodule

// File: rtl/control_logic.sv
// Control decoder top: halt latch, halt gating, phase advance and, when
// CTRL_OUT_REG_EN is defined, a one-cycle output register stage.
module control_logic
  import control_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  control_logic_if.slave bus
);

  ctrl_t      dec_s;
  ctrl_t      gated_s;
  ctrl_t      out_s;
  logic [2:0] nstate_s;
  logic [2:0] nstate_out_s;
  logic       halted_r;

  control_decode u_decode (
    .op     (bus.op),
    .pstate (bus.pstate),
    .zero   (bus.zero),
    .ctrl   (dec_s)
  );

  // Halt latch: set by HLT in OP_ADDR, cleared only by reset
  always_ff @(posedge clk) begin
    if (rst) begin
      halted_r <= 1'b0;
    end else if ((bus.pstate == PH_OP_ADDR) && (bus.op == OP_HLT)) begin
      halted_r <= 1'b1;
    end else begin
      halted_r <= halted_r;
    end
  end

  // While halted, silence all strobes and freeze the phase
  always_comb begin
    if (halted_r) begin
      gated_s  = CTRL_NONE;
      nstate_s = bus.pstate;
    end else begin
      gated_s  = dec_s;
      nstate_s = bus.pstate + 3'd1;
    end
  end

`ifdef CTRL_OUT_REG_EN
  ctrl_t      ctrl_r;
  logic [2:0] nstate_r;

  // Output stage: one cycle of latency after the halt gating
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_r   <= CTRL_NONE;
      nstate_r <= 3'd0;
    end else begin
      ctrl_r   <= gated_s;
      nstate_r <= nstate_s;
    end
  end

  assign out_s        = ctrl_r;
  assign nstate_out_s = nstate_r;
`else
  assign out_s        = gated_s;
  assign nstate_out_s = nstate_s;
`endif

  assign bus.ld_acc  = out_s.ld_acc;
  assign bus.ld_mdr  = out_s.ld_mdr;
  assign bus.ld_ir   = out_s.ld_ir;
  assign bus.dout_en = out_s.dout_en;
  assign bus.ld_pc   = out_s.ld_pc;
  assign bus.inc     = out_s.inc;
  assign bus.sel     = out_s.sel;
  assign bus.rd      = out_s.rd;
  assign bus.wr      = out_s.wr;
  assign bus.nstate  = nstate_out_s;
  assign bus.halted  = halted_r;

endmodule

// File: tb/tb_control_logic.sv
// Table-driven bench for control_logic; adapts to CTRL_OUT_REG_EN latency.
module tb_control_logic;

`ifdef CTRL_OUT_REG_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 0;
`endif

  logic clk;
  logic rst;
  control_logic_if bus ();

  control_logic dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] op;
    logic [2:0] pstate;
    logic       zero;
    logic [8:0] strb;   // {ld_acc,ld_mdr,ld_ir,dout_en,ld_pc,inc,sel,rd,wr}
    logic [2:0] nst;
  } vec_t;

  vec_t vecs [18];
  int   n_pass;
  int   n_total;

  function automatic logic [8:0] strobes();
    return {bus.ld_acc, bus.ld_mdr, bus.ld_ir, bus.dout_en, bus.ld_pc,
            bus.inc, bus.sel, bus.rd, bus.wr};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Drive inputs and wait until the outputs reflect them
  task automatic apply(input logic [2:0] o, input logic [2:0] p, input logic z);
    bus.op     = o;
    bus.pstate = p;
    bus.zero   = z;
    if (LAT != 0) begin
      @(posedge clk);
    end
    #1;
  endtask

  initial begin
    n_pass  = 0;
    n_total = 0;

    vecs[0]  = '{3'd2, 3'd0, 1'b0, 9'b000000100, 3'd1};
    vecs[1]  = '{3'd2, 3'd1, 1'b0, 9'b000000110, 3'd2};
    vecs[2]  = '{3'd2, 3'd2, 1'b0, 9'b001000110, 3'd3};
    vecs[3]  = '{3'd2, 3'd3, 1'b0, 9'b001000110, 3'd4};
    vecs[4]  = '{3'd2, 3'd4, 1'b0, 9'b000001000, 3'd5};
    vecs[5]  = '{3'd2, 3'd5, 1'b0, 9'b010000010, 3'd6};
    vecs[6]  = '{3'd2, 3'd6, 1'b0, 9'b010000010, 3'd7};
    vecs[7]  = '{3'd2, 3'd7, 1'b0, 9'b100000010, 3'd0};
    vecs[8]  = '{3'd6, 3'd6, 1'b0, 9'b000100000, 3'd7};
    vecs[9]  = '{3'd6, 3'd7, 1'b0, 9'b000100001, 3'd0};
    vecs[10] = '{3'd7, 3'd6, 1'b0, 9'b000010000, 3'd7};
    vecs[11] = '{3'd7, 3'd7, 1'b0, 9'b000010000, 3'd0};
    vecs[12] = '{3'd1, 3'd6, 1'b1, 9'b000001000, 3'd7};
    vecs[13] = '{3'd1, 3'd6, 1'b0, 9'b000000000, 3'd7};
    vecs[14] = '{3'd1, 3'd7, 1'b1, 9'b000000000, 3'd0};
    vecs[15] = '{3'd5, 3'd7, 1'b0, 9'b100000010, 3'd0};
    vecs[16] = '{3'd4, 3'd5, 1'b1, 9'b010000010, 3'd6};
    vecs[17] = '{3'd0, 3'd5, 1'b0, 9'b000000000, 3'd6};

    // Reset
    rst = 1'b1;
    bus.op = 3'd2; bus.pstate = 3'd0; bus.zero = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_halted", 32'(bus.halted), 32'd0);
    if (LAT != 0) begin
      check("rst_strb", 32'(strobes()), 32'd0);
      check("rst_nst", 32'(bus.nstate), 32'd0);
    end else begin
      check("rst_strb", 32'(strobes()), 32'h004);
      check("rst_nst", 32'(bus.nstate), 32'd1);
    end

    // Decode table
    for (int i = 0; i < 18; i++) begin
      @(negedge clk);
      apply(vecs[i].op, vecs[i].pstate, vecs[i].zero);
      check($sformatf("vec%0d_strb", i), 32'(strobes()), 32'(vecs[i].strb));
      check($sformatf("vec%0d_nst", i), 32'(bus.nstate), 32'(vecs[i].nst));
      check($sformatf("vec%0d_halt", i), 32'(bus.halted), 32'd0);
    end

`ifdef CTRL_OUT_REG_EN
    // LDA in STORE shows ld_acc exactly one edge later
    @(negedge clk);
    apply(3'd2, 3'd0, 1'b0);
    @(negedge clk);
    bus.op = 3'd5; bus.pstate = 3'd7;
    #1;
    check("lda_pre", 32'(bus.ld_acc), 32'd0);
    @(posedge clk); #1;
    check("lda_post", 32'(bus.ld_acc), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("lda_rst_strb", 32'(strobes()), 32'd0);
    check("lda_rst_nst", 32'(bus.nstate), 32'd0);
`endif

    // HLT in OP_ADDR: inc before the edge, halted after
    @(negedge clk);
    bus.op = 3'd0; bus.pstate = 3'd4; bus.zero = 1'b0;
    #1;
    check("hlt_pre_halt", 32'(bus.halted), 32'd0);
    if (LAT == 0) check("hlt_pre_inc", 32'(bus.inc), 32'd1);
    @(posedge clk); #1;
    check("hlt_halted", 32'(bus.halted), 32'd1);
    if (LAT != 0) begin
      check("hlt_reg_strb", 32'(strobes()), 32'h008);
      check("hlt_reg_nst", 32'(bus.nstate), 32'd5);
    end else begin
      check("hlt_strb", 32'(strobes()), 32'd0);
      check("hlt_nst", 32'(bus.nstate), 32'd4);
    end

    // Halted: everything silent, phase held
    @(negedge clk);
    apply(3'd2, 3'd2, 1'b0);
    check("halt_p2_strb", 32'(strobes()), 32'd0);
    check("halt_p2_nst", 32'(bus.nstate), 32'd2);
    @(negedge clk);
    apply(3'd6, 3'd7, 1'b1);
    check("halt_p7_strb", 32'(strobes()), 32'd0);
    check("halt_p7_nst", 32'(bus.nstate), 32'd7);
    check("halt_p7_halt", 32'(bus.halted), 32'd1);

    // Reset releases halt; decode resumes at pstate 0
    @(negedge clk);
    rst = 1'b1;
    bus.op = 3'd2; bus.pstate = 3'd0; bus.zero = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    check("unhalt", 32'(bus.halted), 32'd0);
    if (LAT != 0) begin
      check("unhalt_reg_strb", 32'(strobes()), 32'd0);
      @(posedge clk); #1;
    end
    check("unhalt_sel", 32'(bus.sel), 32'd1);
    check("unhalt_nst", 32'(bus.nstate), 32'd1);

    // Reset beats a simultaneous HLT/OP_ADDR condition
    @(negedge clk);
    rst = 1'b1;
    bus.op = 3'd0; bus.pstate = 3'd4;
    @(posedge clk); #1;
    rst = 1'b0;
    check("rst_wins", 32'(bus.halted), 32'd0);
    @(negedge clk);
    bus.op = 3'd2;
    @(posedge clk); #1;
    check("rst_wins_after", 32'(bus.halted), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
